imem_ctrl: RTL and testbench
============================

IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive loader writes granted while a fetch waits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port fetch_req, input, 1: fetch request, held high until fetch_valid.
REQ-005 SHALL have port fetch_pc, input, 8: byte address of the instruction's high byte.
REQ-006 SHALL have port fetch_ack, output, 1: one-cycle pulse on the cycle a fetch is accepted.
REQ-007 SHALL have port fetch_valid, output, 1: one-cycle pulse when fetch_inst is updated.
REQ-008 SHALL have port fetch_inst, output, 16: {byte[pc], byte[pc+1]}, held until the next response.
REQ-009 SHALL have ports ld_valid (input, 1), ld_data (input, 8) and ld_ready (output, 1): loader byte stream, transferred when ld_valid and ld_ready are both high.
REQ-010 SHALL have port ld_restart, input, 1: pulse that resets the loader address to 0.
REQ-011 SHALL have port ld_addr, output, 8: next loader write address.
REQ-012 SHALL have ports mem_en, mem_we, mem_addr[7:0] and mem_wdata[7:0] (all outputs), plus mem_rdata[7:0] (input): a single-port byte RAM with 1-cycle synchronous read latency.

Function
REQ-013 SHALL implement states IDLE, RD_HI, RD_LO, RESP.
- IDLE: accepts one request per cycle.
- Fetch path: IDLE -> RD_HI -> RD_LO -> RESP -> IDLE.
- Loader writes complete within IDLE (one write per cycle).
REQ-014 SHALL, on fetch acceptance, pulse fetch_ack and register fetch_pc.
- Fetch accepted in cycle T: mem_addr=pc in T+1 and pc+1 in T+2; fetch_valid in T+3.
REQ-015 SHALL compute pc+1 modulo 256, so pc=0xFF reads bytes 0xFF then 0x00.
REQ-016 SHALL assert ld_ready only in IDLE when the loader is granted.
- Each transfer drives mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data in the same cycle.
- ld_addr increments after each transfer, wrapping 0xFF->0x00.
REQ-017 SHALL grant the loader over a fetch when both request in IDLE, unless STARVE_LIMIT consecutive loader grants occurred with fetch_req high.
- In that case the fetch is granted.
- The starvation counter clears on any fetch grant or when fetch_req is low.
REQ-018 SHALL apply ld_restart before a coincident transfer: the write goes to address 0 and ld_addr becomes 1.
REQ-019 SHALL hold mem_en=0 and mem_we=0 in IDLE when nothing is granted.
- mem_we SHALL be 0 in every non-IDLE state.
REQ-020 SHALL ignore fetch_pc changes after acceptance.

Reset
REQ-021 SHALL, while rst is high, force the following values:
- state=IDLE, fetch_inst=0, ld_addr=0, starvation counter=0;
- fetch_ack, fetch_valid, ld_ready, mem_en, mem_we = 0;
- mem_addr=0, mem_wdata=0.
REQ-022 SHALL abandon an in-flight fetch on reset; no fetch_valid is produced for it.

Configuration
REQ-023 SHALL honour macro IMEM_LOAD_EN.
- Defined: loader path as above.
- Undefined: ld_ready=0, ld_addr=0, loader inputs ignored, mem_we constantly 0; fetch is always granted in IDLE.

Structure
REQ-024 SHALL place in shared package imem_pkg:
- the state enum;
- constants ADDR_W=8, INST_W=16 and the STARVE_LIMIT default.
REQ-025 SHALL be a single module; no sub-module is required. The RAM is external.

Verification
REQ-026 Fetch: RAM[0x10]=0xAB and RAM[0x11]=0xCD, fetch_pc=0x10 -> fetch_inst=0xABCD with fetch_valid exactly 3 cycles after fetch_ack.
REQ-027 Wrap: RAM[0xFF]=0x12 and RAM[0x00]=0x34, fetch_pc=0xFF -> fetch_inst=0x1234.
REQ-028 Load: stream bytes 0x70,0x00,0xE0 after ld_restart -> RAM[0..2] hold those bytes and ld_addr=3; coincident ld_restart with a transfer -> write to address 0 and ld_addr=1.
REQ-029 Starvation: ld_valid held high continuously and fetch_req high -> exactly 4 loader writes, then fetch_ack, then loader writes resume after fetch_valid.
REQ-030 Reset: rst asserted in RD_LO -> outputs 0 asynchronously, no fetch_valid; a new fetch after release completes normally.
REQ-031 With IMEM_LOAD_EN undefined: ld_valid=1 -> ld_ready stays 0 and mem_we stays 0; fetches unaffected.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory controller.
package imem_pkg;

    localparam int ADDR_W           = 8;
    localparam int INST_W           = 16;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_HI = 2'd1,
        RD_LO = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_ctrl.sv
// Instruction fetch controller arbitrating a byte loader against 16-bit fetches
// on one single-port RAM. Loader path is built only when IMEM_LOAD_EN is defined.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ack,
    output logic              fetch_valid,
    output logic [INST_W-1:0] fetch_inst,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    input  logic              ld_restart,
    output logic [ADDR_W-1:0] ld_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t            state, state_nxt;
    logic              idle;
    logic              fetch_grant;
    logic              ld_grant;
    logic [ADDR_W-1:0] ld_waddr;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [7:0]        hi_byte;
    logic [INST_W-1:0] inst_q;

    // Grants are only issued out of reset, since state already reads IDLE while rst is high.
    assign idle   = (state == IDLE) && !rst;
    assign pc_inc = pc_q + ADDR_W'(1);

`ifdef IMEM_LOAD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] ld_addr_q;
    logic              starved;

    assign starved  = fetch_req && (starve_cnt >= CNT_W'(STARVE_LIMIT));
    assign ld_grant = idle && ld_valid && !starved;
    // Restart takes effect before a coincident write lands.
    assign ld_waddr = ld_restart ? '0 : ld_addr_q;
    assign ld_ready = ld_grant;
    assign ld_addr  = ld_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_addr_q  <= '0;
            starve_cnt <= '0;
        end else begin
            if (ld_grant)
                ld_addr_q <= ld_waddr + ADDR_W'(1);
            else if (ld_restart)
                ld_addr_q <= '0;
            if (!fetch_req || fetch_grant)
                starve_cnt <= '0;
            else if (ld_grant)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_ld;

    assign ld_grant  = 1'b0;
    assign ld_waddr  = '0;
    assign ld_ready  = 1'b0;
    assign ld_addr   = '0;
    assign unused_ld = ^{ld_valid, ld_data, ld_restart, (STARVE_LIMIT > 0)};
`endif

    assign fetch_grant = idle && fetch_req && !ld_grant;
    assign fetch_ack   = fetch_grant;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_grant) state_nxt = RD_HI;
            RD_HI:   state_nxt = RD_LO;
            RD_LO:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            inst_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == RESP)
                inst_q <= {hi_byte, mem_rdata};
        end
    end

    // Datapath captures: pc at acceptance, high byte one cycle after its read address.
    always_ff @(posedge clk) begin
        if (fetch_grant)
            pc_q <= fetch_pc;
        if (state == RD_LO)
            hi_byte <= mem_rdata;
    end

    // Low byte arrives from the RAM in RESP, so the response is presented combinationally there.
    assign fetch_valid = (state == RESP);
    assign fetch_inst  = (state == RESP) ? {hi_byte, mem_rdata} : inst_q;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_waddr;
            mem_wdata = ld_data;
        end else if (state == RD_HI) begin
            mem_en   = 1'b1;
            mem_addr = pc_q;
        end else if (state == RD_LO) begin
            mem_en   = 1'b1;
            mem_addr = pc_inc;
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl with a behavioural RAM and byte-array reference model.
module tb_imem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [7:0]  fetch_pc;
    logic        fetch_ack;
    logic        fetch_valid;
    logic [15:0] fetch_inst;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        ld_restart;
    logic [7:0]  ld_addr;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram     [256];
    logic [7:0] ref_mem [256];
    logic       bd_we = 1'b0;
    logic [7:0] bd_addr = 8'd0;
    logic [7:0] bd_data = 8'd0;
`ifdef IMEM_LOAD_EN
    logic [7:0] model_ld_addr = 8'd0;
`endif

    imem_ctrl #(.STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_ack   (fetch_ack),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_restart  (ld_restart),
        .ld_addr     (ld_addr),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM, one-cycle read latency, with a bench backdoor write port.
    always @(posedge clk) begin
        if (bd_we)
            ram[bd_addr] <= bd_data;
        else if (mem_en) begin
            if (mem_we)
                ram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic set_byte(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic fill_ram();
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            bd_we   = 1'b1;
            bd_addr = i[7:0];
            bd_data = 8'($urandom);
            ref_mem[i] = bd_data;
        end
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic do_fetch(input logic [7:0] pc, input string name, output logic [15:0] got);
        logic [7:0]  pc1;
        logic [15:0] exp;
        int t, ack_c;
        bit acked, done;
        pc1 = pc + 8'd1;
        acked = 0; done = 0; ack_c = 0; t = 0; got = '0;
        @(posedge clk); #1;
        fetch_req = 1'b1;
        fetch_pc  = pc;
        while (!done && t < 16) begin
            @(negedge clk);
            if (acked && (t - ack_c) == 1) begin
                checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== pc) begin
                    errors++;
                    $display("FAIL %s hi-read: en=%b we=%b addr=%h, expected en=1 we=0 addr=%h",
                             name, mem_en, mem_we, mem_addr, pc);
                end
            end
            if (acked && (t - ack_c) == 2) begin
                checks++;
                if (mem_en !== 1'b1 || mem_addr !== pc1) begin
                    errors++;
                    $display("FAIL %s lo-read: en=%b addr=%h, expected en=1 addr=%h",
                             name, mem_en, mem_addr, pc1);
                end
            end
            if (!acked && fetch_ack === 1'b1) begin
                acked = 1;
                ack_c = t;
            end
            if (fetch_valid === 1'b1) begin
                done = 1;
                got  = fetch_inst;
                exp  = {ref_mem[pc], ref_mem[pc1]};
                checks++;
                if (!acked || (t - ack_c) != 3) begin
                    errors++;
                    $display("FAIL %s latency: valid %0d cycles after ack (acked=%0d), expected 3",
                             name, t - ack_c, acked);
                end
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s inst: got %h, expected %h", name, got, exp);
                end
            end
            @(posedge clk); #1;
            if (done)
                fetch_req = 1'b0;
            else if (acked)
                fetch_pc = 8'($urandom);
            t++;
        end
        if (!done) begin
            checks++;
            errors++;
            fetch_req = 1'b0;
            $display("FAIL %s timeout: no fetch_valid within %0d cycles", name, t);
        end
        @(negedge clk);
        checks++;
        if (fetch_valid !== 1'b0 || fetch_inst !== got) begin
            errors++;
            $display("FAIL %s hold: valid=%b inst=%h, expected valid=0 inst=%h",
                     name, fetch_valid, fetch_inst, got);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_req = 1'b1; fetch_pc = 8'h55;
        ld_valid = 1'b1; ld_data = 8'hFF; ld_restart = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({fetch_ack, fetch_valid, ld_ready, mem_en, mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset ctrl: ack/valid/ready/en/we=%b, expected 00000",
                     {fetch_ack, fetch_valid, ld_ready, mem_en, mem_we});
        end
        checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset mem bus: addr=%h wdata=%h, expected 00 00", mem_addr, mem_wdata);
        end
        checks++;
        if (fetch_inst !== 16'h0000) begin
            errors++;
            $display("FAIL reset fetch_inst: got %h, expected 0000", fetch_inst);
        end
        checks++;
        if (ld_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset ld_addr: got %h, expected 00", ld_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0; fetch_req = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_ack !== 1'b0 || mem_en !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle quiet: ack=%b en=%b valid=%b, expected 0 0 0",
                     fetch_ack, mem_en, fetch_valid);
        end
    endtask

    task automatic test_fetch();
        logic [15:0] got;
        set_byte(8'h10, 8'hAB);
        set_byte(8'h11, 8'hCD);
        do_fetch(8'h10, "fetch_10", got);
        checks++;
        if (got !== 16'hABCD) begin
            errors++;
            $display("FAIL fetch_10 value: got %h, expected abcd", got);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] got;
        set_byte(8'hFF, 8'h12);
        set_byte(8'h00, 8'h34);
        do_fetch(8'hFF, "fetch_wrap", got);
        checks++;
        if (got !== 16'h1234) begin
            errors++;
            $display("FAIL fetch_wrap value: got %h, expected 1234", got);
        end
    endtask

    task automatic test_random_fetch();
        logic [15:0] got;
        for (int i = 0; i < 16; i++)
            do_fetch(8'($urandom), "fetch_rand", got);
    endtask

    task automatic test_reset_mid_fetch();
        logic [7:0]  pc;
        logic [15:0] got;
        int t;
        bit seen;
        pc = 8'h40 + 8'($urandom_range(0, 15));
        @(posedge clk); #1;
        fetch_req = 1'b1; fetch_pc = pc;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (fetch_ack !== 1'b1 && t < 10);
        checks++;
        if (fetch_ack !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid ack: no fetch_ack within %0d cycles", t);
        end
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== pc + 8'd1) begin
            errors++;
            $display("FAIL rst_mid rd_lo: en=%b addr=%h, expected en=1 addr=%h",
                     mem_en, mem_addr, pc + 8'd1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({fetch_ack, fetch_valid, mem_en, mem_we, ld_ready} !== 5'b0 ||
            mem_addr !== 8'h00 || fetch_inst !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid async: ctrl=%b addr=%h inst=%h, expected 00000 00 0000",
                     {fetch_ack, fetch_valid, mem_en, mem_we, ld_ready}, mem_addr, fetch_inst);
        end
        fetch_req = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (fetch_valid !== 1'b0) seen = 1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef IMEM_LOAD_EN
        model_ld_addr = 8'd0;
`endif
        repeat (4) begin
            @(negedge clk);
            if (fetch_valid !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_mid abandon: fetch_valid seen=1, expected 0");
        end
        do_fetch(8'($urandom), "fetch_after_rst", got);
    endtask

`ifdef IMEM_LOAD_EN
    task automatic test_load();
        logic       v, r;
        logic [7:0] d, wa;
        logic [15:0] got;
        int n;
        for (int i = 0; i < 26; i++) begin
            @(posedge clk); #1;
            case (i)
                0:       begin v = 1'b0; r = 1'b1; d = 8'h00; end
                1:       begin v = 1'b1; r = 1'b0; d = 8'h70; end
                2:       begin v = 1'b1; r = 1'b0; d = 8'h00; end
                3:       begin v = 1'b1; r = 1'b0; d = 8'hE0; end
                4, 9:    begin v = 1'b1; r = (i == 9); d = (i == 9) ? 8'h5A : 8'($urandom); end
                default: begin
                    v = ($urandom_range(0, 3) != 0);
                    r = ($urandom_range(0, 7) == 0);
                    d = 8'($urandom);
                end
            endcase
            ld_valid = v; ld_restart = r; ld_data = d;
            @(negedge clk);
            checks++;
            if (ld_addr !== model_ld_addr) begin
                errors++;
                $display("FAIL load ld_addr step %0d: got %h, expected %h", i, ld_addr, model_ld_addr);
            end
            if (i == 4) begin
                checks++;
                if (ld_addr !== 8'd3 || ram[0] !== 8'h70 || ram[1] !== 8'h00 || ram[2] !== 8'hE0) begin
                    errors++;
                    $display("FAIL load stream: ld_addr=%h ram0..2=%h %h %h, expected 03 70 00 e0",
                             ld_addr, ram[0], ram[1], ram[2]);
                end
            end
            if (i == 10) begin
                checks++;
                if (ld_addr !== 8'd1 || ram[0] !== 8'h5A) begin
                    errors++;
                    $display("FAIL load restart coincident: ld_addr=%h ram0=%h, expected 01 5a",
                             ld_addr, ram[0]);
                end
            end
            wa = r ? 8'd0 : model_ld_addr;
            checks++;
            if (ld_ready !== v) begin
                errors++;
                $display("FAIL load ld_ready step %0d: got %b, expected %b", i, ld_ready, v);
            end
            if (v) begin
                checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== wa || mem_wdata !== d) begin
                    errors++;
                    $display("FAIL load write step %0d: en=%b we=%b addr=%h data=%h, expected 1 1 %h %h",
                             i, mem_en, mem_we, mem_addr, mem_wdata, wa, d);
                end
                ref_mem[wa]   = d;
                model_ld_addr = wa + 8'd1;
            end else if (r) begin
                model_ld_addr = 8'd0;
            end
        end
        @(posedge clk); #1;
        ld_valid = 1'b0; ld_restart = 1'b0;
        @(negedge clk);
        n = 0;
        for (int k = 0; k < 256; k++)
            if (ram[k] !== ref_mem[k]) n++;
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL load ram image: %0d bytes differ, expected 0", n);
        end
        for (int i = 0; i < 4; i++)
            do_fetch(8'($urandom_range(0, 7)), "fetch_loaded", got);
    endtask

    task automatic test_starvation();
        logic [7:0]  pc, pc1;
        logic [15:0] exp;
        int wr_before, wr_mid, cyc, ack_c, val_c;
        bit acked, valid_seen, both;
        @(posedge clk); #1;
        ld_valid = 1'b1; ld_restart = 1'b0; ld_data = 8'($urandom);
        for (int rep = 0; rep < 2; rep++) begin
            pc = 8'($urandom); pc1 = pc + 8'd1;
            wr_before = 0; wr_mid = 0; cyc = 0; ack_c = 0; val_c = 0;
            acked = 0; valid_seen = 0; both = 0; exp = '0;
            fetch_req = 1'b1; fetch_pc = pc;
            while (!valid_seen && cyc < 20) begin
                @(negedge clk);
                if (ld_ready === 1'b1 && ld_valid) begin
                    checks++;
                    if (mem_we !== 1'b1 || mem_addr !== model_ld_addr || mem_wdata !== ld_data) begin
                        errors++;
                        $display("FAIL starve write: we=%b addr=%h data=%h, expected 1 %h %h",
                                 mem_we, mem_addr, mem_wdata, model_ld_addr, ld_data);
                    end
                    ref_mem[model_ld_addr] = ld_data;
                    model_ld_addr = model_ld_addr + 8'd1;
                    if (acked) wr_mid++; else wr_before++;
                    if (fetch_ack === 1'b1) both = 1;
                end
                if (!acked && fetch_ack === 1'b1) begin
                    acked = 1;
                    ack_c = cyc;
                end
                if (fetch_valid === 1'b1) begin
                    valid_seen = 1;
                    val_c = cyc;
                    exp = {ref_mem[pc], ref_mem[pc1]};
                    checks++;
                    if (fetch_inst !== exp) begin
                        errors++;
                        $display("FAIL starve inst: got %h, expected %h", fetch_inst, exp);
                    end
                end
                @(posedge clk); #1;
                ld_data = 8'($urandom);
                if (valid_seen) fetch_req = 1'b0;
                else if (acked) fetch_pc = 8'($urandom);
                cyc++;
            end
            checks++;
            if (wr_before != 4 || !acked || both) begin
                errors++;
                $display("FAIL starve grants: writes before ack=%0d acked=%0d overlap=%0d, expected 4 1 0",
                         wr_before, acked, both);
            end
            checks++;
            if (!valid_seen || wr_mid != 0 || (val_c - ack_c) != 3) begin
                errors++;
                $display("FAIL starve fetch: valid=%0d writes during fetch=%0d latency=%0d, expected 1 0 3",
                         valid_seen, wr_mid, val_c - ack_c);
            end
            @(negedge clk);
            checks++;
            if (ld_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== model_ld_addr) begin
                errors++;
                $display("FAIL starve resume: ready=%b we=%b addr=%h, expected 1 1 %h",
                         ld_ready, mem_we, mem_addr, model_ld_addr);
            end
            if (ld_ready === 1'b1) begin
                ref_mem[model_ld_addr] = ld_data;
                model_ld_addr = model_ld_addr + 8'd1;
            end
            @(posedge clk); #1;
            ld_data = 8'($urandom);
        end
        ld_valid = 1'b0;
    endtask
`else
    task automatic test_loader_disabled();
        logic [15:0] got;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            ld_valid = 1'b1; ld_restart = 1'($urandom); ld_data = 8'($urandom);
            @(negedge clk);
            checks++;
            if (ld_ready !== 1'b0 || mem_we !== 1'b0 || ld_addr !== 8'h00) begin
                errors++;
                $display("FAIL loader disabled: ready=%b we=%b ld_addr=%h, expected 0 0 00",
                         ld_ready, mem_we, ld_addr);
            end
        end
        for (int i = 0; i < 3; i++)
            do_fetch(8'($urandom), "fetch_ld_disabled", got);
        ld_valid = 1'b0; ld_restart = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        fill_ram();
        test_fetch();
        test_wrap();
        test_random_fetch();
        test_reset_mid_fetch();
`ifdef IMEM_LOAD_EN
        test_load();
        test_starvation();
`else
        test_loader_disabled();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
